// File: rtl/mux_glitch_filter.sv
// mux_glitch_filter: synchronizes the hazard-prone output of a 2:1 select
// stage, qualifies each new level over STABLE_CYCLES consecutive samples,
// and publishes a clean registered level, edge pulses and a saturating
// count of rejected transitions.
module mux_glitch_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             dout,
  output logic             rise,
  output logic             fall,
  output logic             busy,
  output logic [CNT_W-1:0] glitch_cnt
);

  // One extra bit so the count can hold STABLE_CYCLES-1 for any legal value.
  localparam int CW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CW-1:0]    LAST_CNT = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]    ONE_CNT  = CW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_QUAL_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_QUAL_LOW  = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] r_sync;
  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [CW-1:0]          r_count;
  logic [CW-1:0]          w_count_nxt;
  logic                   w_s;
  logic                   w_glitch;
  logic                   w_rise_nxt;
  logic                   w_fall_nxt;
  logic                   w_dout_nxt;
  logic                   w_busy_nxt;
  logic                   r_dout;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_busy;
  logic [CNT_W-1:0]       r_glitch_cnt;

  assign w_s = r_sync[SYNC_STAGES-1];

  // Shift the asynchronous input through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
    end
  end

  // Next-state logic: a candidate level must persist for STABLE_CYCLES
  // samples; falling back to the current level mid-qualification is a glitch.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_glitch    = 1'b0;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      ST_LOW: begin
        if (w_s) begin
          w_state_nxt = ST_QUAL_HIGH;
          w_count_nxt = ONE_CNT;
        end else begin
          w_state_nxt = ST_LOW;
        end
      end
      ST_QUAL_HIGH: begin
        if (w_s) begin
          if (r_count == LAST_CNT) begin
            w_state_nxt = ST_HIGH;
            w_count_nxt = '0;
            w_rise_nxt  = 1'b1;
          end else begin
            w_count_nxt = r_count + ONE_CNT;
          end
        end else begin
          w_state_nxt = ST_LOW;
          w_count_nxt = '0;
          w_glitch    = 1'b1;
        end
      end
      ST_HIGH: begin
        if (!w_s) begin
          w_state_nxt = ST_QUAL_LOW;
          w_count_nxt = ONE_CNT;
        end else begin
          w_state_nxt = ST_HIGH;
        end
      end
      ST_QUAL_LOW: begin
        if (!w_s) begin
          if (r_count == LAST_CNT) begin
            w_state_nxt = ST_LOW;
            w_count_nxt = '0;
            w_fall_nxt  = 1'b1;
          end else begin
            w_count_nxt = r_count + ONE_CNT;
          end
        end else begin
          w_state_nxt = ST_HIGH;
          w_count_nxt = '0;
          w_glitch    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_LOW;
        w_count_nxt = '0;
      end
    endcase
  end

  // Output decode of the next state, so dout/busy are registered alongside it.
  always_comb begin
    w_dout_nxt = (w_state_nxt == ST_HIGH) || (w_state_nxt == ST_QUAL_LOW);
    w_busy_nxt = (w_state_nxt == ST_QUAL_HIGH) || (w_state_nxt == ST_QUAL_LOW);
  end

  // State, qualification count and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_LOW;
      r_count <= '0;
      r_dout  <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_dout  <= w_dout_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Saturating glitch counter; a clear request overrides a coincident event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_glitch_cnt <= '0;
    end else if (clr_cnt) begin
      r_glitch_cnt <= '0;
    end else if (w_glitch && (r_glitch_cnt != CNT_MAX)) begin
      r_glitch_cnt <= r_glitch_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_glitch_cnt <= r_glitch_cnt;
    end
  end

  assign dout       = r_dout;
  assign rise       = r_rise;
  assign fall       = r_fall;
  assign busy       = r_busy;
  assign glitch_cnt = r_glitch_cnt;

endmodule

// File: tb/tb_mux_glitch_filter.sv
// Self-checking bench for mux_glitch_filter against a run-length model.
module tb_mux_glitch_filter;

  localparam int SYNC = 2;
  localparam int STAB = 4;
  localparam int CW   = 2;
  // Ticks from the capturing edge (tick 1) to the edge that changes dout.
  localparam int LAT  = SYNC + STAB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          din;
  logic          clr_cnt;
  logic          dout;
  logic          rise;
  logic          fall;
  logic          busy;
  logic [CW-1:0] glitch_cnt;
  logic [CW+3:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a shift queue for the synchronizer, the accepted level,
  // the length of the current run of samples differing from it, and a
  // saturating integer counter.
  logic [SYNC-1:0] m_sync;
  logic            m_dout;
  logic            m_rise;
  logic            m_fall;
  int              m_run;
  int              m_cnt;

  mux_glitch_filter #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STAB),
    .CNT_W        (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .clr_cnt   (clr_cnt),
    .dout      (dout),
    .rise      (rise),
    .fall      (fall),
    .busy      (busy),
    .glitch_cnt(glitch_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {dout, rise, fall, busy, glitch_cnt};

  task automatic model_reset();
    m_sync = '0;
    m_dout = 1'b0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_run  = 0;
    m_cnt  = 0;
  endtask

  function automatic logic [CW+3:0] exp_vec();
    return {m_dout, m_rise, m_fall, (m_run > 0), CW'(m_cnt)};
  endfunction

  // Advance one clock: apply the edge to the model, then park on the negedge.
  task automatic tick();
    logic s;
    logic d;
    logic c;
    logic g;
    d = din;
    c = clr_cnt;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      s = m_sync[SYNC-1];
      g = 1'b0;
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (s != m_dout) begin
        m_run++;
        if (m_run == STAB) begin
          m_dout = s;
          m_rise = s;
          m_fall = ~s;
          m_run  = 0;
        end
      end else if (m_run > 0) begin
        g = 1'b1;
        m_run = 0;
      end
      if (c) m_cnt = 0;
      else if (g && m_cnt < (1 << CW) - 1) m_cnt++;
      m_sync = {m_sync[SYNC-2:0], d};
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    int rise_at;
    int rise_n;
    rst_n = 1'b0; din = 1'b0; clr_cnt = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      din = ~din;
      tick();
      n_checks++;
      if (obs !== '0) begin
        n_fail++;
        $display("FAIL reset_hold cyc %0d: got %b want %b", i, obs, {(CW+4){1'b0}});
      end
    end
    din = 1'b1;
    rst_n = 1'b1;
    rise_at = -1; rise_n = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (rise) begin rise_n++; if (rise_at < 0) rise_at = i; end
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_release cyc %0d: got %b want %b", i, obs, exp_vec());
      end
    end
    n_checks++;
    if (rise_at != LAT || rise_n != 1 || dout !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_latency: rise at %0d (x%0d) dout %b, want at %0d (x1) dout 1", rise_at, rise_n, dout, LAT);
    end
  endtask

  task automatic test_clean_edges();
    int rise_at;
    int fall_at;
    din = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL clean_settle cyc %0d: got %b want %b", i, obs, exp_vec());
      end
    end
    din = 1'b1;
    rise_at = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (rise && rise_at < 0) rise_at = i;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL clean_rise cyc %0d: got %b want %b", i, obs, exp_vec());
      end
    end
    din = 1'b0;
    fall_at = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (fall && fall_at < 0) fall_at = i;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL clean_fall cyc %0d: got %b want %b", i, obs, exp_vec());
      end
    end
    n_checks++;
    if (rise_at != LAT || fall_at != LAT || glitch_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL clean_latency: rise %0d fall %0d cnt %0d, want %0d %0d 0", rise_at, fall_at, glitch_cnt, LAT, LAT);
    end
  endtask

  task automatic test_hazard();
    int busy_n;
    int fall_n;
    int low_n;
    din = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    busy_n = 0; fall_n = 0; low_n = 0;
    for (int i = 0; i < 12; i++) begin
      din = (i < 2) ? 1'b0 : 1'b1;
      tick();
      if (busy) busy_n++;
      if (fall) fall_n++;
      if (!dout) low_n++;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL hazard cyc %0d: got %b want %b", i, obs, exp_vec());
      end
    end
    n_checks++;
    if (busy_n != 2 || fall_n != 0 || low_n != 0 || glitch_cnt !== 2'd1) begin
      n_fail++;
      $display("FAIL hazard_summary: busy %0d fall %0d low %0d cnt %0d, want 2 0 0 1", busy_n, fall_n, low_n, glitch_cnt);
    end
  endtask

  task automatic test_saturation();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 6; i++) begin
        din = (i < 2) ? 1'b0 : 1'b1;
        tick();
        n_checks++;
        if (obs !== exp_vec()) begin
          n_fail++;
          $display("FAIL sat_pulse p%0d cyc %0d: got %b want %b", p, i, obs, exp_vec());
        end
      end
    end
    n_checks++;
    if (glitch_cnt !== 2'd3) begin
      n_fail++;
      $display("FAIL sat_value: got %0d want 3", glitch_cnt);
    end
    // Sixth glitch: the event lands on the third edge after din returns high.
    din = 1'b0; tick(); tick();
    din = 1'b1; tick(); tick();
    clr_cnt = 1'b1; tick();
    clr_cnt = 1'b0;
    n_checks++;
    if (glitch_cnt !== 2'd0 || busy !== 1'b0 || dout !== 1'b1 || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL clr_vs_glitch: got cnt %0d busy %b dout %b, want 0 0 1", glitch_cnt, busy, dout);
    end
  endtask

  task automatic test_async_reset();
    int rise_at;
    din = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    din = 1'b1;
    tick(); tick(); tick();
    n_checks++;
    if (busy !== 1'b1 || dout !== 1'b0) begin
      n_fail++;
      $display("FAIL async_pre: got busy %b dout %b, want 1 0", busy, dout);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL async_immediate: got %b want %b", obs, {(CW+4){1'b0}});
    end
    tick(); tick();
    rst_n = 1'b1;
    rise_at = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (rise && rise_at < 0) rise_at = i;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL async_requal cyc %0d: got %b want %b", i, obs, exp_vec());
      end
    end
    n_checks++;
    if (rise_at != LAT || glitch_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL async_latency: rise %0d cnt %0d, want %0d 0", rise_at, glitch_cnt, LAT);
    end
  endtask

  task automatic test_boundary();
    int rise_n;
    int fall_n;
    din = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    rise_n = 0;
    for (int i = 0; i < STAB - 1 + 10; i++) begin
      din = (i < STAB - 1) ? 1'b1 : 1'b0;
      tick();
      if (rise) rise_n++;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL short_pulse cyc %0d: got %b want %b", i, obs, exp_vec());
      end
    end
    n_checks++;
    if (rise_n != 0 || glitch_cnt !== 2'd1) begin
      n_fail++;
      $display("FAIL short_summary: rise %0d cnt %0d, want 0 1", rise_n, glitch_cnt);
    end
    rise_n = 0; fall_n = 0;
    for (int i = 0; i < STAB + 12; i++) begin
      din = (i < STAB) ? 1'b1 : 1'b0;
      tick();
      if (rise) rise_n++;
      if (fall) fall_n++;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL full_pulse cyc %0d: got %b want %b", i, obs, exp_vec());
      end
    end
    n_checks++;
    if (rise_n != 1 || fall_n != 1 || glitch_cnt !== 2'd1) begin
      n_fail++;
      $display("FAIL full_summary: rise %0d fall %0d cnt %0d, want 1 1 1", rise_n, fall_n, glitch_cnt);
    end
  endtask

  task automatic test_random();
    int run_left;
    run_left = 0;
    for (int i = 0; i < 400; i++) begin
      if (run_left == 0) begin
        din = ~din;
        run_left = $urandom_range(1, 7);
      end
      run_left--;
      clr_cnt = ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0;
      tick();
      n_checks++;
      if (obs !== exp_vec() || (rise && fall)) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %b want %b", i, obs, exp_vec());
      end
    end
    clr_cnt = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_edges();
    test_hazard();
    test_saturation();
    test_async_reset();
    test_boundary();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
